// File: rtl/dijkstra_pkg.sv
// Shared constants, address map and FSM states for the Dijkstra accelerator.
package dijkstra_pkg;
  localparam int N         = 32;
  localparam logic [31:0] INF = 32'hFFFF_FFFF;
  localparam int ADJ_SIZE  = 'h800;
  localparam int RES_BASE  = 'h800;
  localparam int RES_SIZE  = 'h400;
  localparam int PREV_BASE = 'h880;
  localparam int PREV_WORD = (PREV_BASE - RES_BASE) / 4;

  typedef enum logic [2:0] {S_IDLE, S_INIT, S_SELECT, S_RELAX, S_FIN} state_e;

  // Access size is in bits; anything >= 8 covers the whole byte.
  function automatic logic [7:0] size_mask(input logic [3:0] sz);
    return (sz >= 4'd8) ? 8'hFF : 8'((9'd1 << sz) - 9'd1);
  endfunction
endpackage

// File: rtl/dijkstra_bram.sv
// Byte-lane RAM: one wide internal port (byte enables) plus two byte-wide
// slave channels with bit-masked writes. Reads are asynchronous.
module dijkstra_bram #(
  parameter int DEPTH = 1024,
  parameter int WB    = 4,
  localparam int AW   = $clog2(DEPTH),
  localparam int WAW  = $clog2(DEPTH / WB)
) (
  input  logic                 clock,
  input  logic                 a_we_i,
  input  logic [WAW-1:0]       a_addr_i,
  input  logic [WB-1:0]        a_be_i,
  input  logic [8*WB-1:0]      a_wdata_i,
  output logic [8*WB-1:0]      a_rdata_o,
  input  logic [1:0]           b_we_i,
  input  logic [1:0][AW-1:0]   b_addr_i,
  input  logic [1:0][7:0]      b_wdata_i,
  input  logic [1:0][7:0]      b_mask_i,
  output logic [1:0][7:0]      b_rdata_o
);
  logic [7:0] mem [DEPTH];

  always_comb begin
    for (int i = 0; i < WB; i++) a_rdata_o[8*i +: 8] = mem[int'(a_addr_i) * WB + i];
    for (int k = 0; k < 2; k++)  b_rdata_o[k] = mem[b_addr_i[k]];
  end

  // Channel 1 is written last so it wins a same-byte collision.
  always_ff @(posedge clock) begin
    if (a_we_i)
      for (int i = 0; i < WB; i++)
        if (a_be_i[i]) mem[int'(a_addr_i) * WB + i] <= a_wdata_i[8*i +: 8];
    for (int k = 0; k < 2; k++)
      if (b_we_i[k])
        mem[b_addr_i[k]] <= (mem[b_addr_i[k]] & ~b_mask_i[k]) | (b_wdata_i[k] & b_mask_i[k]);
  end
endmodule

// File: rtl/dijkstra_main.sv
// Single-source shortest path from node 0 over a 32-node matrix in RAM.
// Define DIJKSTRA_PREV_EN to also store predecessor bytes at 0x880+v.
module dijkstra_main
  import dijkstra_pkg::*;
#(
  parameter int MEM_var_28859_28863 = 2048,
  parameter int MEM_var_28861_28866 = 1024
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start_port,
  input  logic [1:0]  S_oe_ram,
  input  logic [1:0]  S_we_ram,
  input  logic [23:0] S_addr_ram,
  input  logic [15:0] S_Wdata_ram,
  input  logic [7:0]  S_data_ram_size,
  input  logic [15:0] M_Rdata_ram,
  input  logic [1:0]  M_DataRdy,
  output logic        done_port,
  output logic [15:0] Sout_Rdata_ram,
  output logic [1:0]  Sout_DataRdy,
  output logic [1:0]  Mout_oe_ram,
  output logic [1:0]  Mout_we_ram,
  output logic [23:0] Mout_addr_ram,
  output logic [15:0] Mout_Wdata_ram,
  output logic [7:0]  Mout_data_ram_size
);
  state_e          st_q;
  logic [4:0]      cnt_q, u_q, bidx_q, bidx_d;
  logic [31:0]     dist_q [N];
  logic [N-1:0]    vis_q;
  logic [31:0]     best_q, best_d, du_q, nd;
  logic            found_q, found_d, take, upd, done_q;
  logic [1:0]      rdy_q;
  logic [1:0][7:0] rdat_q;
`ifdef DIJKSTRA_PREV_EN
  logic [7:0]      prev_q [N];
`endif

  logic [1:0][11:0] s_addr;
  logic [1:0][10:0] adj_ba;
  logic [1:0][9:0]  res_ba;
  logic [1:0][7:0]  s_wd, s_mask, adj_rb, res_rb;
  logic [1:0]       adj_hit, res_hit, rd, wr, adj_we, res_we;
  logic [15:0]      adj_w;
  logic             ra_we;
  logic [7:0]       ra_addr;
  logic [3:0]       ra_be;
  logic [31:0]      ra_wdata, ra_rdata;
  logic [15:0]      unused_adj_wr;
  logic             unused_m;

  assign unused_m = ^{M_Rdata_ram, M_DataRdy, ra_rdata};

  always_comb begin
    for (int k = 0; k < 2; k++) begin
      s_addr[k]  = S_addr_ram[12*k +: 12];
      s_wd[k]    = S_Wdata_ram[8*k +: 8];
      s_mask[k]  = size_mask(S_data_ram_size[4*k +: 4]);
      adj_hit[k] = int'(s_addr[k]) < ADJ_SIZE;
      res_hit[k] = int'(s_addr[k]) >= RES_BASE && int'(s_addr[k]) < RES_BASE + RES_SIZE;
      rd[k]      = (st_q == S_IDLE) && S_oe_ram[k] && (adj_hit[k] || res_hit[k]);
      wr[k]      = (st_q == S_IDLE) && S_we_ram[k] && !S_oe_ram[k] && (adj_hit[k] || res_hit[k]);
      adj_we[k]  = wr[k] && adj_hit[k];
      res_we[k]  = wr[k] && res_hit[k];
      adj_ba[k]  = s_addr[k][10:0];
      res_ba[k]  = s_addr[k][9:0];
    end
  end

  // Scan and relax datapath; dist[u] is latched at selection so RELAX needs one read.
  always_comb begin
    take    = !vis_q[cnt_q] && (dist_q[cnt_q] < best_q);
    best_d  = take ? dist_q[cnt_q] : best_q;
    bidx_d  = take ? cnt_q : bidx_q;
    found_d = found_q | take;
    nd      = du_q + {16'h0, adj_w};
    upd     = (st_q == S_RELAX) && !vis_q[cnt_q] && (adj_w != 16'h0) && (nd < dist_q[cnt_q]);
  end

  // Register copies of dist/prev are mirrored into the result RAM as they change.
  always_comb begin
    ra_we    = 1'b0;
    ra_addr  = '0;
    ra_be    = '0;
    ra_wdata = '0;
    unique case (st_q)
      S_INIT: begin
        ra_we = 1'b1; ra_addr = {3'b0, cnt_q}; ra_be = 4'hF;
        ra_wdata = (cnt_q == 5'd0) ? 32'h0 : INF;
      end
      S_RELAX: begin
        ra_we = upd; ra_addr = {3'b0, cnt_q}; ra_be = 4'hF; ra_wdata = nd;
      end
`ifdef DIJKSTRA_PREV_EN
      S_SELECT: begin
        ra_we = 1'b1; ra_addr = 8'(PREV_WORD) + {5'b0, cnt_q[4:2]};
        ra_be = 4'b1 << cnt_q[1:0]; ra_wdata = {4{prev_q[cnt_q]}};
      end
`endif
      default: ;
    endcase
  end

  dijkstra_bram #(.DEPTH(MEM_var_28859_28863), .WB(2)) u_adj (
    .clock(clock), .a_we_i(1'b0), .a_addr_i({u_q, cnt_q}), .a_be_i(2'b00),
    .a_wdata_i(16'h0), .a_rdata_o(adj_w), .b_we_i(adj_we), .b_addr_i(adj_ba),
    .b_wdata_i(s_wd), .b_mask_i(s_mask), .b_rdata_o(adj_rb));

  dijkstra_bram #(.DEPTH(MEM_var_28861_28866), .WB(4)) u_res (
    .clock(clock), .a_we_i(ra_we), .a_addr_i(ra_addr), .a_be_i(ra_be),
    .a_wdata_i(ra_wdata), .a_rdata_o(ra_rdata), .b_we_i(res_we), .b_addr_i(res_ba),
    .b_wdata_i(s_wd), .b_mask_i(s_mask), .b_rdata_o(res_rb));

  assign unused_adj_wr = 16'h0;

  always_ff @(posedge clock) begin
    if (reset) begin
      st_q    <= S_IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      rdy_q   <= '0;
      rdat_q  <= '0;
      best_q  <= INF;
      found_q <= 1'b0;
      bidx_q  <= '0;
      u_q     <= '0;
      du_q    <= '0;
    end else begin
      done_q <= 1'b0;
      rdy_q  <= rd | wr;
      for (int k = 0; k < 2; k++)
        rdat_q[k] <= rd[k] ? (adj_hit[k] ? adj_rb[k] : res_rb[k]) : 8'h0;
      unique case (st_q)
        S_IDLE: if (start_port) begin st_q <= S_INIT; cnt_q <= '0; end
        S_INIT: begin
          dist_q[cnt_q] <= (cnt_q == 5'd0) ? 32'h0 : INF;
          vis_q[cnt_q]  <= 1'b0;
`ifdef DIJKSTRA_PREV_EN
          prev_q[cnt_q] <= 8'hFF;
`endif
          cnt_q <= cnt_q + 5'd1;
          if (cnt_q == 5'd31) begin st_q <= S_SELECT; best_q <= INF; found_q <= 1'b0; end
        end
        S_SELECT: begin
          best_q  <= best_d;
          bidx_q  <= bidx_d;
          found_q <= found_d;
          cnt_q   <= cnt_q + 5'd1;
          if (cnt_q == 5'd31) begin
            if (found_d) begin
              vis_q[bidx_d] <= 1'b1;
              u_q  <= bidx_d;
              du_q <= best_d;
              st_q <= S_RELAX;
            end else st_q <= S_FIN;
          end
        end
        S_RELAX: begin
          if (upd) begin
            dist_q[cnt_q] <= nd;
`ifdef DIJKSTRA_PREV_EN
            prev_q[cnt_q] <= {3'b0, u_q};
`endif
          end
          cnt_q <= cnt_q + 5'd1;
          if (cnt_q == 5'd31) begin st_q <= S_SELECT; best_q <= INF; found_q <= 1'b0; end
        end
        S_FIN: begin done_q <= 1'b1; st_q <= S_IDLE; end
        default: st_q <= S_IDLE;
      endcase
    end
  end

  assign done_port          = done_q;
  assign Sout_DataRdy       = rdy_q;
  assign Sout_Rdata_ram     = rdat_q;
  assign Mout_oe_ram        = 2'b00;
  assign Mout_we_ram        = 2'b00;
  assign Mout_addr_ram      = 24'h0;
  assign Mout_Wdata_ram     = unused_adj_wr;
  assign Mout_data_ram_size = 8'h0;
endmodule

// File: tb/tb_dijkstra_main.sv
// Directed bench for dijkstra_main: slave bus, shortest paths, busy/abort, range.
module tb_dijkstra_main;
  logic        clock = 1'b0, reset = 1'b1, start_port = 1'b0;
  logic [1:0]  S_oe_ram = '0, S_we_ram = '0;
  logic [23:0] S_addr_ram = '0;
  logic [15:0] S_Wdata_ram = '0;
  logic [7:0]  S_data_ram_size = '0;
  logic [15:0] M_Rdata_ram = '0;
  logic [1:0]  M_DataRdy = '0;
  logic        done_port;
  logic [15:0] Sout_Rdata_ram, Mout_Wdata_ram;
  logic [1:0]  Sout_DataRdy, Mout_oe_ram, Mout_we_ram;
  logic [23:0] Mout_addr_ram;
  logic [7:0]  Mout_data_ram_size;
  int checks = 0, errors = 0;
  int nd, first;
  logic [31:0] d;
  logic [7:0]  p;

  always #5 clock = ~clock;

  dijkstra_main dut (
    .clock(clock), .reset(reset), .start_port(start_port),
    .S_oe_ram(S_oe_ram), .S_we_ram(S_we_ram), .S_addr_ram(S_addr_ram),
    .S_Wdata_ram(S_Wdata_ram), .S_data_ram_size(S_data_ram_size),
    .M_Rdata_ram(M_Rdata_ram), .M_DataRdy(M_DataRdy), .done_port(done_port),
    .Sout_Rdata_ram(Sout_Rdata_ram), .Sout_DataRdy(Sout_DataRdy),
    .Mout_oe_ram(Mout_oe_ram), .Mout_we_ram(Mout_we_ram), .Mout_addr_ram(Mout_addr_ram),
    .Mout_Wdata_ram(Mout_Wdata_ram), .Mout_data_ram_size(Mout_data_ram_size));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic bus(input logic [1:0] oe, input logic [1:0] we, input logic [11:0] a1,
                     input logic [11:0] a0, input logic [7:0] d1, input logic [7:0] d0,
                     input logic [3:0] z);
    S_oe_ram = oe; S_we_ram = we; S_addr_ram = {a1, a0};
    S_Wdata_ram = {d1, d0}; S_data_ram_size = {z, z};
    @(negedge clock);
    S_oe_ram = '0; S_we_ram = '0;
  endtask

  task automatic wr_w(input int i, input int j, input logic [15:0] w);
    logic [11:0] a;
    a = 12'(2 * (32 * i + j));
    bus(2'b00, 2'b11, a + 12'd1, a, w[15:8], w[7:0], 4'd8);
  endtask

  task automatic rd_dist(input int v, output logic [31:0] r);
    logic [11:0] a;
    a = 12'(12'h800 + 4 * v);
    bus(2'b11, 2'b00, a + 12'd1, a, 8'h0, 8'h0, 4'd8);
    r[15:0] = Sout_Rdata_ram;
    bus(2'b11, 2'b00, a + 12'd3, a + 12'd2, 8'h0, 8'h0, 4'd8);
    r[31:16] = Sout_Rdata_ram;
  endtask

  task automatic rd_byte(input logic [11:0] a, output logic [7:0] r);
    bus(2'b01, 2'b00, 12'h0, a, 8'h0, 8'h0, 4'd8);
    r = Sout_Rdata_ram[7:0];
  endtask

  // Start, then probe the bus and re-assert start while busy; optional mid-run reset.
  task automatic run(input int rst_at, output int ndone, output int first_c);
    ndone = 0; first_c = 0;
    start_port = 1'b1;
    @(negedge clock);
    start_port = 1'b0;
    for (int c = 1; c <= 3000; c++) begin
      if (c == 100) begin
        S_oe_ram = 2'b01; S_we_ram = 2'b10; S_addr_ram = {12'h900, 12'h800};
        S_Wdata_ram = 16'h5500; S_data_ram_size = 8'h88;
      end
      if (c == 150) start_port = 1'b1;
      if (c == rst_at) reset = 1'b1;
      @(negedge clock);
      if (done_port) begin ndone++; if (first_c == 0) first_c = c; end
      if (c == 100 && rst_at == 0) begin
        chk("busy_ack", 32'(Sout_DataRdy), 32'h0);
        chk("busy_data", 32'(Sout_Rdata_ram), 32'h0);
      end
      if (c == 100) begin S_oe_ram = '0; S_we_ram = '0; end
      if (c == 150) start_port = 1'b0;
      if (rst_at != 0 && c == rst_at + 1) begin reset = 1'b0; break; end
    end
  endtask

  initial begin
    @(negedge clock);
    @(negedge clock);
    chk("rst_done", 32'(done_port), 32'h0);
    chk("rst_rdy", 32'(Sout_DataRdy), 32'h0);
    chk("rst_rdata", 32'(Sout_Rdata_ram), 32'h0);
    chk("rst_master", 32'(|{Mout_oe_ram, Mout_we_ram, Mout_addr_ram, Mout_Wdata_ram, Mout_data_ram_size}), 32'h0);
    reset = 1'b0;

    for (int i = 0; i < 2048; i += 2) bus(2'b00, 2'b11, 12'(i + 1), 12'(i), 8'h0, 8'h0, 4'd8);

    bus(2'b00, 2'b11, 12'h801, 12'h002, 8'h3C, 8'hA5, 4'd8);
    chk("wr_ack", 32'(Sout_DataRdy), 32'h3);
    chk("wr_data0", 32'(Sout_Rdata_ram), 32'h0);
    bus(2'b11, 2'b00, 12'h801, 12'h002, 8'h0, 8'h0, 4'd8);
    chk("rd_ack", 32'(Sout_DataRdy), 32'h3);
    chk("rd_data", 32'(Sout_Rdata_ram), 32'h3CA5);

    bus(2'b00, 2'b01, 12'h0, 12'h900, 8'h0, 8'h00, 4'd8);
    bus(2'b00, 2'b01, 12'h0, 12'h900, 8'h0, 8'hFF, 4'd4);
    rd_byte(12'h900, p);
    chk("size4_mask", 32'(p), 32'h0F);

    bus(2'b01, 2'b01, 12'h0, 12'h900, 8'h0, 8'h99, 4'd8);
    chk("oewe_ack", 32'(Sout_DataRdy), 32'h1);
    chk("oewe_data", 32'(Sout_Rdata_ram), 32'h000F);
    rd_byte(12'h900, p);
    chk("oewe_nowrite", 32'(p), 32'h0F);

    bus(2'b00, 2'b11, 12'h901, 12'h901, 8'h22, 8'h11, 4'd8);
    rd_byte(12'h901, p);
    chk("ch1_wins", 32'(p), 32'h22);

    bus(2'b11, 2'b00, 12'hFFF, 12'hC00, 8'h0, 8'h0, 4'd8);
    chk("oor_ack", 32'(Sout_DataRdy), 32'h0);
    chk("oor_data", 32'(Sout_Rdata_ram), 32'h0);
    bus(2'b00, 2'b11, 12'hC01, 12'hC00, 8'h77, 8'h77, 4'd8);
    chk("oor_wr_ack", 32'(Sout_DataRdy), 32'h0);
    rd_byte(12'h400, p);
    chk("oor_no_alias_adj", 32'(p), 32'h00);
    rd_byte(12'h801, p);
    chk("oor_no_alias_res", 32'(p), 32'h3C);

    // Chain 0->1->2 with a longer direct 0->2 edge; node 3 unreachable.
    wr_w(0, 1, 16'd5); wr_w(1, 2, 16'd7); wr_w(0, 2, 16'd20);
    run(0, nd, first);
    chk("chain_ndone", 32'(nd), 32'd1);
    chk("chain_latency", 32'(first > 0 && first <= 2200), 32'd1);
    rd_dist(0, d); chk("chain_d0", d, 32'd0);
    rd_dist(1, d); chk("chain_d1", d, 32'd5);
    rd_dist(2, d); chk("chain_d2", d, 32'd12);
    rd_dist(3, d); chk("chain_d3", d, 32'hFFFF_FFFF);
    rd_byte(12'h900, p);
    chk("busy_wr_dropped", 32'(p), 32'h0F);
`ifdef DIJKSTRA_PREV_EN
    rd_byte(12'h880, p); chk("chain_p0", 32'(p), 32'hFF);
    rd_byte(12'h881, p); chk("chain_p1", 32'(p), 32'h00);
    rd_byte(12'h882, p); chk("chain_p2", 32'(p), 32'h01);
    rd_byte(12'h883, p); chk("chain_p3", 32'(p), 32'hFF);
`endif

    run(75, nd, first);
    chk("abort_ndone", 32'(nd), 32'd0);
    chk("abort_done", 32'(done_port), 32'h0);
    chk("abort_rdy", 32'(Sout_DataRdy), 32'h0);
    run(0, nd, first);
    chk("rerun_ndone", 32'(nd), 32'd1);
    rd_dist(2, d); chk("rerun_d2", d, 32'd12);

    // Equal-cost paths to node 3 through nodes 1 and 2.
    wr_w(0, 1, 16'd0); wr_w(1, 2, 16'd0); wr_w(0, 2, 16'd0);
    wr_w(0, 1, 16'd3); wr_w(0, 2, 16'd3); wr_w(1, 3, 16'd1); wr_w(2, 3, 16'd1);
    run(0, nd, first);
    chk("tie_ndone", 32'(nd), 32'd1);
    rd_dist(1, d); chk("tie_d1", d, 32'd3);
    rd_dist(2, d); chk("tie_d2", d, 32'd3);
    rd_dist(3, d); chk("tie_d3", d, 32'd4);
`ifdef DIJKSTRA_PREV_EN
    rd_byte(12'h883, p); chk("tie_p3", 32'(p), 32'h01);
`endif

    wr_w(0, 2, 16'd0); wr_w(1, 3, 16'd0); wr_w(2, 3, 16'd0);
    for (int i = 0; i < 31; i++) wr_w(i, i + 1, 16'hFFFF);
    run(0, nd, first);
    chk("long_ndone", 32'(nd), 32'd1);
    rd_dist(16, d); chk("long_d16", d, 32'h000F_FFF0);
    rd_dist(31, d); chk("long_d31", d, 32'h001E_FFE1);
`ifdef DIJKSTRA_PREV_EN
    rd_byte(12'h89F, p); chk("long_p31", 32'(p), 32'h1E);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
